// File: rtl/or_nway_reduce_pkg.sv
// Shared definitions for or_nway_reduce: FSM state encodings and ceil-log2.
package or_nway_reduce_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_SCAN = 2'd1;
   localparam logic [1:0] ST_DONE = 2'd2;

   // Ceil-log2 of a positive value; returns 0 for 1.
   function automatic int clog2(input int value);
      int r;
      int v;
      r = 0;
      v = value - 1;
      while (v > 0) begin
         r = r + 1;
         v = v >>> 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/or_nway_reduce_chunk_enc.sv
// or_chunk_enc: combinational OR and lowest-set-bit encoder for one chunk.
// lidx is 0 when the chunk is all zero; its width is at least 1 bit.
module or_chunk_enc
   import or_nway_reduce_pkg::*;
#(
   parameter int CHUNK = 4,
   localparam int LIDXW = (CHUNK > 1) ? clog2(CHUNK) : 1
) (
   input  logic [CHUNK-1:0] chunk,
   output logic             nz,
   output logic [LIDXW-1:0] lidx
);

   // OR of the chunk and position of its lowest set bit (scan from the top so the lowest wins).
   always_comb begin
      nz   = |chunk;
      lidx = '0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (chunk[i]) begin
            lidx = LIDXW'(i);
         end else begin
            lidx = lidx;
         end
      end
   end

endmodule

// File: rtl/or_nway_reduce.sv
// or_nway_reduce: multi-cycle OR reduction of a WIDTH-bit word, CHUNK bits per cycle.
// Returns any (OR of all bits) and first_idx (lowest set bit, 0 when any=0).
// Optional build macro OR_REDUCE_EARLY_EXIT_EN: leave SCAN as soon as the first
// non-zero chunk is found; undefined gives constant NCHUNK-cycle latency.
module or_nway_reduce
   import or_nway_reduce_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CHUNK = 4,
   localparam int NCHUNK = WIDTH / CHUNK,
   localparam int IDXW = clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             any,
   output logic [IDXW-1:0]  first_idx,
   output logic             busy
);

   localparam int CNTW  = (NCHUNK > 1) ? clog2(NCHUNK) : 1;
   localparam int LIDXW = (CHUNK > 1) ? clog2(CHUNK) : 1;

   logic [1:0]       state_r;
   logic [1:0]       state_nx_s;
   logic [CNTW-1:0]  cnt_r;
   logic [WIDTH-1:0] word_r;
   logic [IDXW-1:0]  base_s;
   logic [WIDTH-1:0] shifted_s;
   logic [CHUNK-1:0] chunk_s;
   logic             nz_s;
   logic [LIDXW-1:0] lidx_s;
   logic             last_s;
   logic             early_s;

   // Bit offset of the current chunk; k*CHUNK < WIDTH so it fits in IDXW bits.
   assign base_s    = IDXW'(cnt_r) * IDXW'(CHUNK);
   assign shifted_s = word_r >> base_s;
   assign chunk_s   = shifted_s[CHUNK-1:0];
   assign last_s    = (cnt_r == CNTW'(NCHUNK - 1));

`ifdef OR_REDUCE_EARLY_EXIT_EN
   assign early_s = ~any & nz_s;
`else
   assign early_s = 1'b0;
`endif

   or_chunk_enc #(.CHUNK(CHUNK)) u_enc (
      .chunk (chunk_s),
      .nz    (nz_s),
      .lidx  (lidx_s)
   );

   // Next-state decode for the IDLE -> SCAN -> DONE handshake sequence.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (in_valid) begin
               state_nx_s = ST_SCAN;
            end else begin
               state_nx_s = ST_IDLE;
            end
         end
         ST_SCAN: begin
            if (last_s || early_s) begin
               state_nx_s = ST_DONE;
            end else begin
               state_nx_s = ST_SCAN;
            end
         end
         ST_DONE: begin
            if (out_ready) begin
               state_nx_s = ST_IDLE;
            end else begin
               state_nx_s = ST_DONE;
            end
         end
         default: state_nx_s = ST_IDLE;
      endcase
   end

   // State, registered status flags, word capture, chunk counter and result update.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_r   <= ST_IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         any       <= 1'b0;
         first_idx <= '0;
         cnt_r     <= '0;
         word_r    <= '0;
      end else begin
         state_r   <= state_nx_s;
         in_ready  <= (state_nx_s == ST_IDLE);
         out_valid <= (state_nx_s == ST_DONE);
         busy      <= (state_nx_s == ST_SCAN);
         case (state_r)
            ST_IDLE: begin
               if (in_valid) begin
                  word_r    <= in_data;
                  any       <= 1'b0;
                  first_idx <= '0;
                  cnt_r     <= '0;
               end
            end
            ST_SCAN: begin
               if (!any && nz_s) begin
                  any       <= 1'b1;
                  first_idx <= base_s + IDXW'(lidx_s);
               end
               // Hold at the last chunk index rather than wrapping.
               if (!last_s) begin
                  cnt_r <= cnt_r + CNTW'(1);
               end
            end
            default: begin
               cnt_r <= cnt_r;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_or_nway_reduce.sv
// Self-checking bench for or_nway_reduce: 16/4 default instance plus a 32/8 instance.
module tb_or_nway_reduce;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid, in_ready, out_valid, out_ready, any, busy;
   logic [15:0] in_data;
   logic [3:0]  first_idx;

   logic        b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_any, b_busy;
   logic [31:0] b_in_data;
   logic [4:0]  b_first_idx;

   int n_vec = 0;
   int n_err = 0;

   or_nway_reduce #(.WIDTH(16), .CHUNK(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
      .any(any), .first_idx(first_idx), .busy(busy)
   );

   or_nway_reduce #(.WIDTH(32), .CHUNK(8)) dut_w (
      .clk(clk), .reset(reset), .in_valid(b_in_valid), .in_ready(b_in_ready),
      .in_data(b_in_data), .out_valid(b_out_valid), .out_ready(b_out_ready),
      .any(b_any), .first_idx(b_first_idx), .busy(b_busy)
   );

   always #5 clk = ~clk;

   // Reference: lowest set bit by plain search, 0 for an all-zero word.
   function automatic int ref_first(input logic [31:0] w, input int width);
      for (int i = 0; i < width; i++)
         if (w[i]) return i;
      return 0;
   endfunction

   // Reference latency from accept edge to out_valid.
   function automatic int ref_lat(input logic [31:0] w, input int width, input int chunk);
`ifdef OR_REDUCE_EARLY_EXIT_EN
      if (w != 32'h0) return ref_first(w, width) / chunk + 1;
`endif
      return width / chunk;
   endfunction

   // Offer one word to the 16-bit DUT and check the result when out_valid rises.
   task automatic apply_word(input logic [15:0] d, input logic rel);
      int cyc;
      int exp_lat;
      int exp_idx;
      logic exp_any;
      exp_any = (d != 16'h0);
      exp_idx = ref_first({16'h0, d}, 16);
      exp_lat = ref_lat({16'h0, d}, 16, 4);
      out_ready = rel;
      @(negedge clk);
      cyc = 0;
      while (in_ready !== 1'b1 && cyc < 20) begin
         @(negedge clk);
         cyc++;
      end
      n_vec++;
      if (in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL accept_ready: in_ready=%b required 1", in_ready);
      end
      in_valid = 1'b1;
      in_data  = d;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      in_data  = 16'($urandom);
      cyc = 0;
      while (out_valid !== 1'b1 && cyc < 40) begin
         n_vec++;
         if (busy !== 1'b1 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL scan_flags: busy=%b in_ready=%b required 1/0", busy, in_ready);
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      n_vec++;
      if (cyc !== exp_lat) begin
         n_err++;
         $display("FAIL latency: word=%h got %0d cycles required %0d", d, cyc, exp_lat);
      end
      n_vec++;
      if (any !== exp_any || first_idx !== 4'(exp_idx)) begin
         n_err++;
         $display("FAIL result: word=%h any=%b idx=%0d required any=%b idx=%0d",
                  d, any, first_idx, exp_any, exp_idx);
      end
      n_vec++;
      if (in_ready !== 1'b0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL done_flags: in_ready=%b busy=%b required 0/0", in_ready, busy);
      end
   endtask

   // After a word completes with out_ready=1, the next edge must release it.
   task automatic check_release();
      @(posedge clk);
      #1;
      n_vec++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
         n_err++;
         $display("FAIL release: out_valid=%b in_ready=%b required 0/1", out_valid, in_ready);
      end
   endtask

   task automatic test_reset();
      reset = 1'b1;
      in_valid = 1'b0; in_data = 16'h0; out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = 32'h0; b_out_ready = 1'b1;
      #12;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || any !== 1'b0 ||
          first_idx !== 4'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL reset_values: rdy=%b ov=%b any=%b idx=%0d busy=%b required 1/0/0/0/0",
                  in_ready, out_valid, any, first_idx, busy);
      end
      @(negedge clk);
      reset = 1'b0;
   endtask

   task automatic test_directed();
      logic [15:0] pats [4];
      pats[0] = 16'h0000; pats[1] = 16'h0100; pats[2] = 16'h8001; pats[3] = 16'h8000;
      for (int i = 0; i < 4; i++) begin
         apply_word(pats[i], 1'b1);
         check_release();
      end
   endtask

   task automatic test_hold();
      apply_word(16'h8000, 1'b0);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         in_valid = 1'b1;
         in_data  = 16'h0001;
         @(posedge clk);
         #1;
         n_vec++;
         if (out_valid !== 1'b1 || any !== 1'b1 || first_idx !== 4'd15 || in_ready !== 1'b0) begin
            n_err++;
            $display("FAIL hold: ov=%b any=%b idx=%0d rdy=%b required 1/1/15/0",
                     out_valid, any, first_idx, in_ready);
         end
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_release();
      apply_word(16'h0001, 1'b1);
      check_release();
   endtask

   task automatic test_reset_mid_scan();
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = 16'h0010;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      @(posedge clk);
      #2;
      reset = 1'b1;
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0 || any !== 1'b0 ||
          first_idx !== 4'd0 || busy !== 1'b0) begin
         n_err++;
         $display("FAIL async_reset: rdy=%b ov=%b any=%b idx=%0d busy=%b required 1/0/0/0/0",
                  in_ready, out_valid, any, first_idx, busy);
      end
      @(negedge clk);
      reset = 1'b0;
      @(posedge clk);
      #1;
      n_vec++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
         n_err++;
         $display("FAIL post_reset_idle: rdy=%b ov=%b required 1/0", in_ready, out_valid);
      end
      apply_word(16'h0600, 1'b1);
      check_release();
   endtask

   task automatic test_random();
      logic [15:0] d;
      for (int i = 0; i < 40; i++) begin
         case ($urandom_range(0, 3))
            0: d = 16'($urandom);
            1: d = 16'h1 << $urandom_range(0, 15);
            2: d = 16'h0;
            default: d = 16'($urandom & $urandom & $urandom);
         endcase
         apply_word(d, 1'b1);
         check_release();
      end
   endtask

   task automatic test_wide();
      logic [31:0] d;
      int cyc;
      for (int i = 0; i < 6; i++) begin
         if (i == 0) d = 32'h0400_0000;
         else if (i == 1) d = 32'h8000_0000;
         else d = $urandom & $urandom;
         @(negedge clk);
         b_in_valid = 1'b1;
         b_in_data  = d;
         @(posedge clk);
         #1;
         b_in_valid = 1'b0;
         cyc = 0;
         while (b_out_valid !== 1'b1 && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
         end
         n_vec++;
         if (cyc !== ref_lat(d, 32, 8)) begin
            n_err++;
            $display("FAIL wide_latency: word=%h got %0d required %0d", d, cyc, ref_lat(d, 32, 8));
         end
         n_vec++;
         if (b_any !== (d != 32'h0) || b_first_idx !== 5'(ref_first(d, 32))) begin
            n_err++;
            $display("FAIL wide_result: word=%h any=%b idx=%0d required idx=%0d",
                     d, b_any, b_first_idx, ref_first(d, 32));
         end
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_hold();
      test_reset_mid_scan();
      test_random();
      test_wide();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
